// File: rtl/seq_multiplier_pkg.sv
// mult_pkg: state encoding and counter sizing shared by the sequential multiplier
package mult_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: operand/product valid-ready bus for the sequential multiplier
interface seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic in_valid, in_ready, signed_mode, out_valid, out_ready;
    logic [WIDTH-1:0] A, B;
    logic [2*WIDTH-1:0] P;
    modport master (
        output in_valid, A, B, signed_mode, out_ready,
        input  in_ready, out_valid, P
    );
    modport slave (
        input  in_valid, A, B, signed_mode, out_ready,
        output in_ready, out_valid, P
    );
endinterface

// File: rtl/seq_multiplier_datapath.sv
// seq_mult_datapath: magnitude conversion, radix-2 add/shift accumulator and final sign fix-up
module seq_mult_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               last,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic [2*WIDTH-1:0] p
);
    logic [WIDTH-1:0] mcand, mplier;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [WIDTH:0] sum;
    logic neg;
    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mplier[0] ? mcand : '0};
    assign acc_nx = {sum, acc[WIDTH-1:1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            p      <= '0;
        end else if (load) begin
            mcand  <= mag(a, signed_mode);
            mplier <= mag(b, signed_mode);
            acc    <= '0;
            neg    <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            acc    <= acc_nx;
            mplier <= mplier >> 1;
            if (last)
                p <= neg ? -acc_nx : acc_nx;
        end
    end
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: fixed-latency shift-add multiplier, one product per WIDTH+2 cycles over valid/ready
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_multiplier_if.slave bus
);
    localparam int CW = clog2(WIDTH + 1);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic accept, last, busy;
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign busy   = (state == BUSY);
    assign accept = bus.in_valid && bus.in_ready;
    assign last   = busy && (cnt == CW'(1));
    always_comb begin
        state_nx = state;
        state_nx = accept ? BUSY
                 : last ? DONE
                 : (bus.out_valid && bus.out_ready) ? IDLE
                 : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= accept ? CW'(WIDTH) : busy ? cnt - CW'(1) : cnt;
        end
    end
    seq_mult_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (accept),
        .step        (busy),
        .last        (last),
        .a           (bus.A),
        .b           (bus.B),
        .signed_mode (bus.signed_mode),
        .p           (bus.P)
    );
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed table, reset/backpressure sequences and random scoreboard at WIDTH 32 and 8
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(32)) i32 ();
    seq_multiplier_if #(.WIDTH(8))  i8 ();
    seq_multiplier #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(i32.slave));
    seq_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
        logic [63:0] p;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: interpret operands in the chosen mode, multiply as integers, keep 2*w bits
    function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic sm, input int w);
        logic [63:0] x, y, m;
        m = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (2 * w)) - 64'd1;
        x = {32'd0, a};
        y = {32'd0, b};
        if (sm && a[w-1]) x = x - (64'd1 << w);
        if (sm && b[w-1]) y = y - (64'd1 << w);
        return (x * y) & m;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return m;
            2: return 32'd1 << (w - 1);
            3: return (32'd1 << (w - 1)) - 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sm, output int n);
        i32.A = a;
        i32.B = b;
        i32.signed_mode = sm;
        i32.in_valid = 1'b1;
        @(posedge clk); #1;
        i32.in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!i32.out_valid && n < 100);
    endtask

    task automatic rnd32(input int n);
        logic [63:0] q[$];
        int acc = 0, res = 0, cyc = 0;
        while (res < n && cyc < 40000) begin
            @(posedge clk); #1;
            i32.in_valid = (acc < n) && ($urandom_range(0, 3) != 0);
            i32.A = pick(32);
            i32.B = pick(32);
            i32.signed_mode = 1'($urandom_range(0, 1));
            i32.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (i32.in_valid && i32.in_ready) begin
                q.push_back(golden(i32.A, i32.B, i32.signed_mode, 32));
                acc++;
            end
            if (i32.out_valid && i32.out_ready) begin
                if (q.size() == 0) chk("r32_extra", 64'd1, 64'd0);
                else chk("r32_p", i32.P, q.pop_front());
                res++;
            end
            cyc++;
        end
        i32.in_valid = 1'b0;
        i32.out_ready = 1'b0;
        chk("r32_count", 64'(res), 64'(n));
        chk("r32_pending", 64'(q.size()), 64'd0);
    endtask

    task automatic rnd8(input int n);
        logic [63:0] q[$];
        int acc = 0, res = 0, cyc = 0;
        while (res < n && cyc < 40000) begin
            @(posedge clk); #1;
            i8.in_valid = (acc < n) && ($urandom_range(0, 3) != 0);
            i8.A = 8'(pick(8));
            i8.B = 8'(pick(8));
            i8.signed_mode = 1'($urandom_range(0, 1));
            i8.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (i8.in_valid && i8.in_ready) begin
                q.push_back(golden({24'd0, i8.A}, {24'd0, i8.B}, i8.signed_mode, 8));
                acc++;
            end
            if (i8.out_valid && i8.out_ready) begin
                if (q.size() == 0) chk("r8_extra", 64'd1, 64'd0);
                else chk("r8_p", {48'd0, i8.P}, q.pop_front());
                res++;
            end
            cyc++;
        end
        i8.in_valid = 1'b0;
        i8.out_ready = 1'b0;
        chk("r8_count", 64'(res), 64'(n));
        chk("r8_pending", 64'(q.size()), 64'd0);
    endtask

    initial begin
        vec_t v[7];
        int n;
        v[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        v[1] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        v[2] = '{32'hFFFF_FFFD, 32'd7,         1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
        v[3] = '{32'd0,         32'hFFFF_FFFF, 1'b1, 64'd0};
        v[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000};
        v[5] = '{32'hFFFF_FFFF, 32'd2,         1'b0, 64'h0000_0001_FFFF_FFFE};
        v[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000};
        {i32.in_valid, i32.out_ready, i32.signed_mode, i32.A, i32.B} = '0;
        {i8.in_valid, i8.out_ready, i8.signed_mode, i8.A, i8.B} = '0;
        #2;
        chk("rst_in_ready", 64'(i32.in_ready), 64'd1);
        chk("rst_out_valid", 64'(i32.out_valid), 64'd0);
        chk("rst_p", i32.P, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (v[i]) begin
            op32(v[i].a, v[i].b, v[i].sm, n);
            chk($sformatf("lat%0d", i), 64'(n), 64'd32);
            chk($sformatf("p%0d", i), i32.P, v[i].p);
            i32.out_ready = 1'b1;
            @(posedge clk); #1;
            i32.out_ready = 1'b0;
            chk($sformatf("idle_rdy%0d", i), 64'(i32.in_ready), 64'd1);
            chk($sformatf("idle_ov%0d", i), 64'(i32.out_valid), 64'd0);
        end

        // Reset in the middle of an operation must discard it
        i32.A = 32'd9;
        i32.B = 32'd9;
        i32.signed_mode = 1'b0;
        i32.in_valid = 1'b1;
        @(posedge clk); #1;
        i32.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("midrst_in_ready", 64'(i32.in_ready), 64'd1);
        chk("midrst_out_valid", 64'(i32.out_valid), 64'd0);
        chk("midrst_p", i32.P, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (i32.out_valid) n++;
        end
        chk("midrst_no_ov", 64'(n), 64'd0);

        // Output backpressure holds the result and ignores new operands
        op32(32'd123, 32'hFFFF_FFFB, 1'b1, n);
        chk("bp_lat", 64'(n), 64'd32);
        repeat (20) begin
            @(negedge clk);
            chk("bp_p", i32.P, 64'hFFFF_FFFF_FFFF_FD99);
            chk("bp_ov", 64'(i32.out_valid), 64'd1);
            chk("bp_rdy", 64'(i32.in_ready), 64'd0);
            @(posedge clk); #1;
            i32.in_valid = 1'($urandom_range(0, 1));
            i32.A = $urandom;
        end
        i32.in_valid = 1'b0;
        i32.out_ready = 1'b1;
        @(posedge clk); #1;
        i32.out_ready = 1'b0;
        chk("bp_rel_rdy", 64'(i32.in_ready), 64'd1);
        chk("bp_rel_ov", 64'(i32.out_valid), 64'd0);

        fork
            rnd32(600);
            rnd8(600);
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
